// File: rtl/twos_pkg.sv
// twos_pkg: shared state encodings and default operand width for the two's-complement datapath.
package twos_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_neg_cell.sv
// serial_neg_cell: one step of the LSB-first negation rule.
// Bits are copied up to and including the first 1, then inverted.
module serial_neg_cell (
  input  logic b,
  input  logic seen_one,
  output logic o,
  output logic seen_one_next
);
  assign o = seen_one ? ~b : b;
  assign seen_one_next = seen_one | b;
endmodule

// File: rtl/twos_to_signmag.sv
// twos_to_signmag: decode a two's-complement operand into sign and magnitude.
// Negative operands are negated bit-serially, so their magnitude takes WIDTH extra cycles.
module twos_to_signmag
  import twos_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             SIGN,
  output logic [WIDTH-1:0] MAGNITUDE,
  output logic             IS_MIN
);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             o;
  logic             seen_one_next;
  serial_neg_cell u_cell (
    .b            (shreg[0]),
    .seen_one     (seen_one),
    .o            (o),
    .seen_one_next(seen_one_next)
  );
  assign IN_READY  = state == ST_IDLE;
  assign OUT_VALID = state == ST_DONE;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      SIGN      <= 1'b0;
      MAGNITUDE <= '0;
      IS_MIN    <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (IN_VALID) begin
          SIGN   <= IN[WIDTH-1];
          IS_MIN <= IN == MIN_VAL;
          if (IN[WIDTH-1]) begin
            shreg    <= IN;
            cnt      <= '0;
            seen_one <= 1'b0;
            state    <= ST_SHIFT;
          end else begin
            MAGNITUDE <= IN;
            state     <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          seen_one  <= seen_one_next;
          MAGNITUDE <= {o, MAGNITUDE[WIDTH-1:1]};
          shreg     <= shreg >> 1;
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_DONE;
        end
        ST_DONE: if (OUT_READY) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twos_to_signmag.sv
// tb_twos_to_signmag: scoreboard bench for the two's-complement to sign-magnitude decoder.
module tb_twos_to_signmag;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       sign;
  logic [7:0] magnitude;
  logic       is_min;
  int         checks = 0;
  int         passes = 0;
  logic [9:0] sb[$];
  logic       ov_q = 1'b0;
  twos_to_signmag dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN       (in_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .SIGN     (sign),
    .MAGNITUDE(magnitude),
    .IS_MIN   (is_min)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [9:0] model(input logic [7:0] x);
    logic [7:0] m;
    m = x[7] ? 8'(0 - int'(x)) : x;
    return {x[7], x == 8'h80, m};
  endfunction
  always @(negedge clk) begin
    logic [9:0] e;
    if (out_valid && !ov_q) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        chk("sign", 32'(sign), 32'(e[9]));
        chk("is_min", 32'(is_min), 32'(e[8]));
        chk("magnitude", 32'(magnitude), 32'(e[7:0]));
      end
    end
    ov_q = out_valid;
  end
  task automatic send(input logic [7:0] x);
    int lat;
    @(negedge clk);
    in_data = x;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'(1));
    sb.push_back(model(x));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'h00;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), x[7] ? 32'(9) : 32'(1));
  endtask
  initial begin
    logic [7:0] vec[8] = '{8'h05, 8'hFB, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h01, 8'h81};
    logic       seen;
    in_valid = 1'b1;
    in_data = 8'h33;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sign", 32'(sign), 32'(0));
    chk("rst_magnitude", 32'(magnitude), 32'(0));
    chk("rst_is_min", 32'(is_min), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_accept_in_rst", 32'(out_valid), 32'(0));
    foreach (vec[i]) begin
      send(vec[i]);
      @(negedge clk);
      chk("in_ready_back", 32'(in_ready), 32'(1));
      chk("out_valid_drop", 32'(out_valid), 32'(0));
    end
    out_ready = 1'b0;
    send(8'hC8);
    in_data = 8'h11;
    in_valid = 1'b1;
    sb.push_back(model(8'h11));
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_sign", 32'(sign), 32'(1));
      chk("hold_magnitude", 32'(magnitude), 32'(8'h38));
      chk("hold_no_accept", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 32'(in_ready), 32'(1));
    chk("stall_release_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'h00;
    chk("queued_pos_latency", 32'(out_valid), 32'(1));
    @(negedge clk);
    in_data = 8'h9C;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'h00;
    chk("shift_busy", 32'(in_ready), 32'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_magnitude", 32'(magnitude), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("midrst_no_output", 32'(seen), 32'(0));
    send(8'h00);
    @(negedge clk);
    chk("final_in_ready", 32'(in_ready), 32'(1));
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
